// File: rtl/conv2d_mc.sv
// Multi-channel 2-D convolution engine: one tap per cycle, bias + shift requantisation to int8.
// Optional CONV_PAD_EN: when defined, the pad input adds zero padding; otherwise pad is ignored.
module conv2d_mc #(
    parameter int unsigned DSIZE = 256,
    parameter int unsigned CH    = 2,
    parameter int unsigned KMAX  = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [7:0]                  data_width,
    input  logic [7:0]                  data_height,
    input  logic [3:0]                  kernel_width,
    input  logic [3:0]                  kernel_height,
    input  logic [3:0]                  stride_x,
    input  logic [3:0]                  stride_y,
    input  logic [1:0]                  pad,
    input  logic [3:0]                  shift,
    input  logic [15:0]                 bias,
    input  logic [8*CH*KMAX*KMAX-1:0]   kernel,
    input  logic [$clog2(CH*DSIZE)-1:0] mi_addr,
    input  logic [31:0]                 mi_data,
    input  logic                        mi_wr,
    input  logic [$clog2(DSIZE)-1:0]    mo_addr,
    output logic [31:0]                 mo_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);
    localparam int unsigned IAW = $clog2(CH * DSIZE);
    localparam int unsigned OAW = $clog2(DSIZE);
    localparam int unsigned CW  = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state;
    logic [3:0]         kx, ky;
    logic [CW-1:0]      c;
    logic [9:0]         wx, wy;
    logic [OAW-1:0]     oaddr;
    logic signed [23:0] acc;

    logic [7:0] di   [CH*DSIZE];
    logic [7:0] dout [DSIZE];

    logic [1:0] pad_eff;
`ifdef CONV_PAD_EN
    assign pad_eff = pad;
`else
    logic unused_pad;
    assign unused_pad = ^pad;
    assign pad_eff    = 2'd0;
`endif

    logic [9:0] pw, ph;
    logic       cfg_ok;
    assign pw = {2'b00, data_width} + {7'd0, pad_eff, 1'b0};
    assign ph = {2'b00, data_height} + {7'd0, pad_eff, 1'b0};
    assign cfg_ok = (kernel_width != 4'd0) && (kernel_width <= 4'(KMAX)) &&
                    (kernel_height != 4'd0) && (kernel_height <= 4'(KMAX)) &&
                    (stride_x != 4'd0) && (stride_y != 4'd0) &&
                    ({6'd0, kernel_width} <= pw) && ({6'd0, kernel_height} <= ph);

    logic signed [10:0] ix, iy;
    logic               in_range;
    logic [IAW-1:0]     di_addr;
    int unsigned        kidx;
    logic [7:0]         pix, ktap;
    logic signed [15:0] prod;
    logic signed [23:0] sum, shifted, bias_ext;
    logic [7:0]         qout;
    logic               win_last, x_end, y_end;

    always_comb begin
        ix = $signed({1'b0, wx}) + $signed({7'd0, kx}) - $signed({9'd0, pad_eff});
        iy = $signed({1'b0, wy}) + $signed({7'd0, ky}) - $signed({9'd0, pad_eff});
`ifdef CONV_PAD_EN
        in_range = !ix[10] && !iy[10] && (ix < $signed({3'd0, data_width})) &&
                   (iy < $signed({3'd0, data_height}));
`else
        in_range = 1'b1;
`endif
        di_addr  = IAW'(32'(c) * 32'(DSIZE) + 32'(iy) * 32'(data_width) + 32'(ix));
        pix      = in_range ? di[di_addr] : 8'd0;
        kidx     = (32'(c) * KMAX + 32'(ky)) * KMAX + 32'(kx);
        ktap     = kernel[8*kidx +: 8];
        prod     = $signed(pix) * $signed(ktap);
        bias_ext = $signed({{8{bias[15]}}, bias});
        sum      = acc + $signed({{8{prod[15]}}, prod});
        shifted  = sum >>> shift;
        if (shifted > 24'sd127)       qout = 8'h7f;
        else if (shifted < -24'sd128) qout = 8'h80;
        else                          qout = shifted[7:0];
        x_end    = (wx + 10'(stride_x) + 10'(kernel_width)) > pw;
        y_end    = (wy + 10'(stride_y) + 10'(kernel_height)) > ph;
        win_last = (kx == kernel_width - 4'd1) && (ky == kernel_height - 4'd1) &&
                   (c == CW'(CH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            kx    <= '0;
            ky    <= '0;
            c     <= '0;
            wx    <= '0;
            wy    <= '0;
            oaddr <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        err   <= !cfg_ok;
                        done  <= !cfg_ok;
                        busy  <= cfg_ok;
                        state <= cfg_ok ? StCalc : StDone;
                        kx    <= '0;
                        ky    <= '0;
                        c     <= '0;
                        wx    <= '0;
                        wy    <= '0;
                        oaddr <= '0;
                        acc   <= bias_ext;
                    end
                end
                StCalc: begin
                    acc <= sum;
                    if (kx != kernel_width - 4'd1) begin
                        kx <= kx + 4'd1;
                    end else begin
                        kx <= '0;
                        if (ky != kernel_height - 4'd1) begin
                            ky <= ky + 4'd1;
                        end else begin
                            ky <= '0;
                            if (c != CW'(CH - 1)) begin
                                c <= c + CW'(1);
                            end else begin
                                // Window complete: its byte is written below, start the next.
                                c     <= '0;
                                acc   <= bias_ext;
                                oaddr <= oaddr + OAW'(1);
                                if (!x_end) begin
                                    wx <= wx + 10'(stride_x);
                                end else begin
                                    wx <= '0;
                                    if (!y_end) begin
                                        wy <= wy + 10'(stride_y);
                                    end else begin
                                        wy    <= '0;
                                        state <= StDone;
                                        busy  <= 1'b0;
                                        done  <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                StDone:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Memories are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mi_wr && !busy) begin
            for (int i = 0; i < 4; i++) di[IAW'(32'(mi_addr) + 32'(i))] <= mi_data[8*i +: 8];
        end
        if (state == StCalc && win_last) dout[oaddr] <= qout;
    end

    always_comb begin
        mo_data = '0;
        for (int i = 0; i < 4; i++) mo_data[8*i +: 8] = dout[OAW'(32'(mo_addr) + 32'(i))];
    end

endmodule

// File: tb/tb_conv2d_mc.sv
// Self-checking bench for conv2d_mc: directed cases plus randomized runs against a loop-level model.
module tb_conv2d_mc;
    localparam int DSIZE = 256;
    localparam int CH    = 2;
    localparam int KMAX  = 3;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [7:0]                data_width = '0, data_height = '0;
    logic [3:0]                kernel_width = '0, kernel_height = '0;
    logic [3:0]                stride_x = '0, stride_y = '0;
    logic [1:0]                pad = '0;
    logic [3:0]                shift = '0;
    logic [15:0]               bias = '0;
    logic [8*CH*KMAX*KMAX-1:0] kernel = '0;
    logic [8:0]                mi_addr = '0;
    logic [31:0]               mi_data = '0;
    logic                      mi_wr = 1'b0;
    logic [7:0]                mo_addr = '0;
    logic [31:0]               mo_data;
    logic                      busy, done, err;

    conv2d_mc #(.DSIZE(DSIZE), .CH(CH), .KMAX(KMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_width(data_width), .data_height(data_height),
        .kernel_width(kernel_width), .kernel_height(kernel_height),
        .stride_x(stride_x), .stride_y(stride_y), .pad(pad), .shift(shift), .bias(bias),
        .kernel(kernel), .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
        .mo_addr(mo_addr), .mo_data(mo_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] di_m [CH*DSIZE];
    logic [7:0] do_m [DSIZE];
    bit         do_known [DSIZE];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sb(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic int pad_e();
`ifdef CONV_PAD_EN
        return int'(pad);
`else
        return 0;
`endif
    endfunction

    // Reference: straightforward nested loops over windows and taps using integer arithmetic.
    task automatic model_run(output int ncyc, output bit bad);
        int kw, kh, sx, sy, w, h, p, pw, ph, n;
        kw = int'(kernel_width);  kh = int'(kernel_height);
        sx = int'(stride_x);      sy = int'(stride_y);
        w  = int'(data_width);    h  = int'(data_height);
        p  = pad_e();  pw = w + 2 * p;  ph = h + 2 * p;
        bad = (kw == 0) || (kw > KMAX) || (kh == 0) || (kh > KMAX) || (sx == 0) ||
              (sy == 0) || (kw > pw) || (kh > ph);
        ncyc = 0;
        if (bad) return;
        n = 0;
        for (int wy = 0; wy + kh <= ph; wy += sy) begin
            for (int wx = 0; wx + kw <= pw; wx += sx) begin
                int acc;
                acc = int'($signed(bias));
                for (int ch = 0; ch < CH; ch++)
                    for (int ky = 0; ky < kh; ky++)
                        for (int kx = 0; kx < kw; kx++) begin
                            int ixx, iyy, v;
                            ixx = wx + kx - p;  iyy = wy + ky - p;  v = 0;
                            if (ixx >= 0 && ixx < w && iyy >= 0 && iyy < h)
                                v = sb(di_m[(ch * DSIZE + iyy * w + ixx) % (CH * DSIZE)]);
                            acc += v * sb(kernel[((ch * KMAX + ky) * KMAX + kx) * 8 +: 8]);
                        end
                acc = acc >>> shift;
                if (acc > 127)  acc = 127;
                if (acc < -128) acc = -128;
                do_m[n % DSIZE]     = 8'(acc);
                do_known[n % DSIZE] = 1'b1;
                n++;
            end
        end
        ncyc = n * CH * kw * kh;
    endtask

    task automatic wr_word(input int a, input logic [31:0] d);
        @(negedge clk);
        mi_addr = 9'(a);  mi_data = d;  mi_wr = 1'b1;
        for (int i = 0; i < 4; i++) di_m[(a + i) % (CH * DSIZE)] = d[8*i +: 8];
    endtask

    // mode 0: constant, 1: byte index, 2: random
    task automatic fill_plane(input int ch, input int mode, input logic [7:0] val);
        for (int a = 0; a < DSIZE; a += 4) begin
            logic [31:0] wd;
            for (int i = 0; i < 4; i++)
                wd[8*i +: 8] = (mode == 0) ? val : (mode == 1) ? 8'(a + i) : 8'($urandom);
            wr_word(ch * DSIZE + a, wd);
        end
        @(negedge clk);
        mi_wr = 1'b0;
    endtask

    // mode 0: all taps val, 1: centre tap only, 2: random
    task automatic set_kernel(input int ch, input int mode, input logic [7:0] val);
        for (int ky = 0; ky < KMAX; ky++)
            for (int kx = 0; kx < KMAX; kx++)
                kernel[((ch * KMAX + ky) * KMAX + kx) * 8 +: 8] =
                    (mode == 0) ? val : (mode == 2) ? 8'($urandom) :
                    (ky == 1 && kx == 1) ? val : 8'd0;
    endtask

    task automatic set_cfg(input int w, input int h, input int kw, input int kh, input int sx,
                           input int sy, input int p, input int sh, input int b);
        data_width = 8'(w);  data_height = 8'(h);  kernel_width = 4'(kw);
        kernel_height = 4'(kh);  stride_x = 4'(sx);  stride_y = 4'(sy);
        pad = 2'(p);  shift = 4'(sh);  bias = 16'(b);
    endtask

    task automatic read_do(input int a, output logic [31:0] wd);
        mo_addr = 8'(a);
        #1;
        wd = mo_data;
    endtask

    task automatic compare_do(input string tag);
        for (int a = 0; a < DSIZE; a += 4) begin
            logic [31:0] mask, expw, obs;
            mask = '0;  expw = '0;
            for (int i = 0; i < 4; i++) if (do_known[a + i]) begin
                mask[8*i +: 8] = 8'hff;
                expw[8*i +: 8] = do_m[a + i];
            end
            if (mask != 0) begin
                read_do(a, obs);
                check($sformatf("%s:do[%0d]", tag, a), obs & mask, expw);
            end
        end
    endtask

    task automatic run_check(input string tag, input bit with_wr, input int wa,
                             input logic [31:0] wd, output int cycles);
        int exp_cyc;
        bit bad, done_early;
        @(negedge clk);
        if (with_wr) begin
            mi_addr = 9'(wa);  mi_data = wd;  mi_wr = 1'b1;
            for (int i = 0; i < 4; i++) di_m[(wa + i) % (CH * DSIZE)] = wd[8*i +: 8];
        end
        start = 1'b1;
        model_run(exp_cyc, bad);
        @(negedge clk);
        start = 1'b0;  mi_wr = 1'b0;
        cycles = 0;  done_early = 1'b0;
        while (busy && cycles < 20000) begin
            cycles++;
            if (done) done_early = 1'b1;
            @(negedge clk);
        end
        check({tag, ":cycles"}, 32'(cycles), 32'(exp_cyc));
        check({tag, ":done_early"}, 32'(done_early), 32'd0);
        check({tag, ":done"}, 32'(done), 32'd1);
        check({tag, ":err"}, 32'(err), 32'(bad));
        @(negedge clk);
        check({tag, ":done_once"}, 32'(done), 32'd0);
        compare_do(tag);
    endtask

    initial begin
        int cyc;
        logic [31:0] wd;
        for (int i = 0; i < DSIZE; i++) do_known[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst:busy", 32'(busy), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Two channels, all-ones kernels
        fill_plane(0, 0, 8'd1);
        fill_plane(1, 0, 8'd2);
        set_kernel(0, 0, 8'd1);
        set_kernel(1, 0, 8'd1);
        set_cfg(4, 4, 3, 3, 1, 1, 0, 0, 0);
        run_check("two_ch", 1'b0, 0, '0, cyc);
        check("two_ch:calc72", 32'(cyc), 32'd72);
        read_do(0, wd);
        check("two_ch:word0", wd, 32'h1b1b1b1b);

        // Saturation (channel 1 kernel zeroed)
        fill_plane(0, 0, 8'd127);
        set_kernel(0, 0, 8'd127);
        set_kernel(1, 0, 8'd0);
        set_cfg(3, 3, 3, 3, 1, 1, 0, 0, 0);
        run_check("sat_pos", 1'b0, 0, '0, cyc);
        read_do(0, wd);
        check("sat_pos:byte0", 32'(wd[7:0]), 32'h7f);
        set_kernel(0, 0, 8'h81);
        run_check("sat_neg", 1'b0, 0, '0, cyc);
        read_do(0, wd);
        check("sat_neg:byte0", 32'(wd[7:0]), 32'h80);
        fill_plane(0, 0, 8'd0);
        set_cfg(3, 3, 3, 3, 1, 1, 0, 2, -4);
        run_check("bias_shift", 1'b0, 0, '0, cyc);
        read_do(0, wd);
        check("bias_shift:byte0", 32'(wd[7:0]), 32'hff);

        // Stride 2 with centre-tap kernel
        fill_plane(0, 1, 8'd0);
        set_kernel(0, 1, 8'd1);
        set_cfg(5, 5, 3, 3, 2, 2, 0, 0, 0);
        run_check("stride", 1'b0, 0, '0, cyc);
        read_do(0, wd);
        check("stride:word0", wd, 32'h12100806);

`ifdef CONV_PAD_EN
        fill_plane(0, 0, 8'd1);
        set_kernel(0, 0, 8'd1);
        set_cfg(3, 3, 3, 3, 1, 1, 1, 0, 0);
        run_check("pad", 1'b0, 0, '0, cyc);
        read_do(0, wd);
        check("pad:word0", wd, 32'h06040604);
        read_do(4, wd);
        check("pad:word1", wd, 32'h06040609);
        read_do(8, wd);
        check("pad:byte8", 32'(wd[7:0]), 32'h04);
`endif

        // Invalid config, then a valid run clears err
        set_cfg(5, 5, 0, 3, 1, 1, 0, 0, 0);
        run_check("invalid", 1'b0, 0, '0, cyc);
        check("invalid:cycles0", 32'(cyc), 32'd0);
        set_cfg(5, 5, 3, 3, 2, 2, 0, 0, 0);
        run_check("revalid", 1'b0, 0, '0, cyc);
        check("revalid:err_clear", 32'(err), 32'd0);

        // Reset mid-run, then a full rerun of the same job
        fill_plane(0, 2, 8'd0);
        fill_plane(1, 2, 8'd0);
        set_kernel(0, 2, 8'd0);
        set_kernel(1, 2, 8'd0);
        set_cfg(6, 6, 1, 1, 1, 1, 0, 1, 3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort:busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort:busy", 32'(busy), 32'd0);
        check("abort:done", 32'(done), 32'd0);
        @(negedge clk);
        check("abort:no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        run_check("rerun", 1'b0, 0, '0, cyc);

        // Input write in the same cycle as start
        run_check("wr_start", 1'b1, 0, $urandom, cyc);

        // Randomized configurations
        for (int it = 0; it < 6; it++) begin
            fill_plane(0, 2, 8'd0);
            fill_plane(1, 2, 8'd0);
            set_kernel(0, 2, 8'd0);
            set_kernel(1, 2, 8'd0);
            set_cfg($urandom_range(2, 12), $urandom_range(2, 12),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(1, 3),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3),
                    $urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 11),
                    int'($urandom_range(0, 65535)));
            run_check($sformatf("rand%0d", it), 1'b0, 0, '0, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
